// File: rtl/mult_pkg.sv
// Shared types for the sequential shift-and-add multiplier.
package mult_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } mult_state_t;

endpackage

// File: rtl/full_adder_nb.sv
// n-bit adder with carry in/out; the single adder on the multiplier datapath.
module full_adder_nb #(
   parameter int n = 32
) (
   input  logic [n-1:0] a,
   input  logic [n-1:0] b,
   input  logic         cin,
   output logic [n-1:0] sum,
   output logic         cout
);

   logic [n:0] total;

   // Operands are zero-extended by one bit so the carry out lands in total[n].
   assign total       = {1'b0, a} + {1'b0, b} + {{n{1'b0}}, cin};
   assign {cout, sum} = total;

endmodule

// File: rtl/seq_multiplier_nb.sv
// Unsigned n x n -> 2n shift-and-add multiplier, one iteration per clock,
// built around a single full_adder_nb.
module seq_multiplier_nb
   import mult_pkg::*;
#(
   parameter int n = 32
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           start,
   input  logic [n-1:0]   a,
   input  logic [n-1:0]   b,
   output logic           busy,
   output logic           done,
   output logic [2*n-1:0] product
);

   localparam int cw = $clog2(n) + 1;
   localparam logic [cw-1:0] last_iter = cw'(n - 1);

   mult_state_t state, state_nxt;
   logic [n-1:0]  mcand;
   logic [n-1:0]  hi;
   logic [n-1:0]  lo;
   logic [cw-1:0] cnt;

   logic [n-1:0] addend;
   logic [n-1:0] sum;
   logic         cout;
   logic         load;
   logic         step;

   // lo[0] is the current multiplier bit: add the multiplicand or nothing.
   assign addend = lo[0] ? mcand : '0;

   full_adder_nb #(.n(n)) u_adder (
      .a   (hi),
      .b   (addend),
      .cin (1'b0),
      .sum (sum),
      .cout(cout)
   );

   // NOTE: every output of this block gets a default first so no latch is inferred.
   always_comb begin
      state_nxt = state;
      load      = 1'b0;
      step      = 1'b0;
      busy      = (state == RUN);
      done      = (state == DONE);
      unique case (state)
         IDLE: begin
            if (start) begin
               load      = 1'b1;
               state_nxt = RUN;
            end
         end
         RUN: begin
            step = 1'b1;
            if (cnt == last_iter) state_nxt = DONE;
         end
         DONE: begin
            load      = start;
            state_nxt = start ? RUN : IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values of its neighbours.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         mcand <= '0;
         hi    <= '0;
         lo    <= '0;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         if (load) begin
            mcand <= a;
            lo    <= b;
            hi    <= '0;
            cnt   <= '0;
         end else if (step) begin
            // The carry becomes the new top bit of hi, so the shift loses nothing.
            {hi, lo} <= {cout, sum, lo[n-1:1]};
            cnt      <= cnt + cw'(1);
         end
      end
   end

   assign product = {hi, lo};

endmodule
